asym_chunk_fifo: RTL and testbench

ASYM_CHUNK_FIFO -- requirements
Module: asym_chunk_fifo

---
 rtl/asym_chunk_fifo.sv | 139 +++++++++++++
 tb/tb_asym_chunk_fifo.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/asym_chunk_fifo.sv
// Asymmetric chunk FIFO: narrow lane writes are packed into wide chunks that pop whole.
// Optional zero padding of unwritten lanes: define ASYM_CHUNK_FIFO_ZERO_PAD_EN.
module asym_chunk_fifo #(
    parameter int WRITE_WIDTH    = 8,
    parameter int READ_WIDTH_MUL = 27,
    parameter int NUM_CHUNKS     = 35,
    localparam int LANE_CNT_W    = $clog2(READ_WIDTH_MUL + 1),
    localparam int COUNT_W       = $clog2(NUM_CHUNKS + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [WRITE_WIDTH-1:0]                wdata,
    input  logic                                  we,
    input  logic                                  w_next_chunk,
    output logic                                  w_full,
    input  logic                                  rd_en,
    output logic [READ_WIDTH_MUL*WRITE_WIDTH-1:0] rdata,
    output logic [LANE_CNT_W-1:0]                 rlanes,
    output logic                                  rvalid,
    output logic                                  empty,
    output logic [COUNT_W-1:0]                    count,
    output logic                                  ovf,
    output logic                                  udf
);

    localparam int LIDX_W = (READ_WIDTH_MUL > 1) ? $clog2(READ_WIDTH_MUL) : 1;
    localparam int PTR_W  = $clog2(NUM_CHUNKS);
    localparam int DATA_W = READ_WIDTH_MUL * WRITE_WIDTH;

    logic [PTR_W-1:0]       r_wp;
    logic [PTR_W-1:0]       r_rp;
    logic [LIDX_W-1:0]      r_lidx;
    logic [COUNT_W-1:0]     r_count;
    logic                   r_ovf;
    logic                   r_udf;
    logic                   r_rvalid;
    logic [DATA_W-1:0]      r_rdata;
    logic [LANE_CNT_W-1:0]  r_rlanes;

    logic [WRITE_WIDTH-1:0] r_mem_data  [NUM_CHUNKS][READ_WIDTH_MUL];
    logic [LANE_CNT_W-1:0]  r_mem_lanes [NUM_CHUNKS];

    logic                   w_is_full;
    logic                   w_is_empty;
    logic                   w_last_lane;
    logic                   w_wr_acc;
    logic                   w_commit;
    logic                   w_pop;
    logic [LANE_CNT_W-1:0]  w_commit_lanes;
    logic [LANE_CNT_W-1:0]  w_pop_lanes;
    logic [DATA_W-1:0]      w_pop_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_CHUNKS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Flags come from the registered count, so a fresh commit is poppable one cycle later.
    assign w_is_full   = (r_count == COUNT_W'(NUM_CHUNKS));
    assign w_is_empty  = (r_count == '0);
    assign w_last_lane = (r_lidx == LIDX_W'(READ_WIDTH_MUL - 1));
    assign w_wr_acc    = we & ~w_is_full;
    assign w_commit    = ~w_is_full & ((we & w_last_lane) |
                                       (w_next_chunk & (we | (r_lidx != '0))));
    assign w_commit_lanes = LANE_CNT_W'(r_lidx) + LANE_CNT_W'(we);
    assign w_pop       = rd_en & ~w_is_empty;
    assign w_pop_lanes = r_mem_lanes[r_rp];

    always_comb begin
        w_pop_data = '0;
        for (int i = 0; i < READ_WIDTH_MUL; i++) begin
`ifdef ASYM_CHUNK_FIFO_ZERO_PAD_EN
            if (LANE_CNT_W'(i) < w_pop_lanes)
                w_pop_data[i*WRITE_WIDTH +: WRITE_WIDTH] = r_mem_data[r_rp][i];
`else
            w_pop_data[i*WRITE_WIDTH +: WRITE_WIDTH] = r_mem_data[r_rp][i];
`endif
        end
    end

    // NOTE: storage is deliberately left out of reset; pointers and count alone define
    // what is valid, and an unreset array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_wr_acc)
            r_mem_data[r_wp][r_lidx] <= wdata;
        if (w_commit)
            r_mem_lanes[r_wp] <= w_commit_lanes;
    end

    // NOTE: every register here uses <= so all reads in this edge see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp     <= '0;
            r_rp     <= '0;
            r_lidx   <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rlanes <= '0;
        end else begin
            r_rvalid <= w_pop;

            if (w_commit) begin
                r_wp   <= ptr_inc(r_wp);
                r_lidx <= '0;
            end else if (w_wr_acc) begin
                r_lidx <= r_lidx + LIDX_W'(1);
            end

            if (w_pop) begin
                r_rp     <= ptr_inc(r_rp);
                r_rdata  <= w_pop_data;
                r_rlanes <= w_pop_lanes;
            end

            case ({w_commit, w_pop})
                2'b10:   r_count <= r_count + COUNT_W'(1);
                2'b01:   r_count <= r_count - COUNT_W'(1);
                default: r_count <= r_count;
            endcase

            if (we & w_is_full)
                r_ovf <= 1'b1;
            if (rd_en & w_is_empty)
                r_udf <= 1'b1;
        end
    end

    assign w_full = w_is_full;
    assign empty  = w_is_empty;
    assign count  = r_count;
    assign ovf    = r_ovf;
    assign udf    = r_udf;
    assign rvalid = r_rvalid;
    assign rdata  = r_rdata;
    assign rlanes = r_rlanes;

endmodule

// File: tb/tb_asym_chunk_fifo.sv
// Directed self-checking bench for asym_chunk_fifo (8-bit lanes, 3 lanes/chunk, 2 slots).
module tb_asym_chunk_fifo;

    localparam int WW  = 8;
    localparam int RWM = 3;
    localparam int NC  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [WW-1:0] wdata;
    logic          we;
    logic          w_next_chunk;
    logic          w_full;
    logic          rd_en;
    logic [RWM*WW-1:0] rdata;
    logic [1:0]    rlanes;
    logic          rvalid;
    logic          empty;
    logic [1:0]    count;
    logic          ovf;
    logic          udf;

    int n_cmp = 0;
    int n_bad = 0;

    asym_chunk_fifo #(.WRITE_WIDTH(WW), .READ_WIDTH_MUL(RWM), .NUM_CHUNKS(NC)) dut (
        .clk(clk), .rst(rst), .wdata(wdata), .we(we), .w_next_chunk(w_next_chunk),
        .w_full(w_full), .rd_en(rd_en), .rdata(rdata), .rlanes(rlanes), .rvalid(rvalid),
        .empty(empty), .count(count), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, let one rising edge pass, sample at the falling edge.
    task automatic cyc(input logic r, input logic w, input logic [WW-1:0] d,
                       input logic n, input logic rd);
        rst = r; we = w; wdata = d; w_next_chunk = n; rd_en = rd;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; we = 1'b0; w_next_chunk = 1'b0; rd_en = 1'b0;
    endtask

    task automatic wr(input logic [WW-1:0] d);
        cyc(1'b0, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic pop();
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".count"},  64'(count),  64'd0);
        check({tag, ".empty"},  64'(empty),  64'd1);
        check({tag, ".w_full"}, 64'(w_full), 64'd0);
        check({tag, ".rvalid"}, 64'(rvalid), 64'd0);
        check({tag, ".rdata"},  64'(rdata),  64'd0);
        check({tag, ".rlanes"}, 64'(rlanes), 64'd0);
        check({tag, ".ovf"},    64'(ovf),    64'd0);
        check({tag, ".udf"},    64'(udf),    64'd0);
    endtask

    initial begin
        logic [RWM*WW-1:0] exp_data;

        rst = 1'b1; we = 1'b0; wdata = '0; w_next_chunk = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        check_reset_state("reset");

        // Full chunk of three lanes, then pop.
        wr(8'h11); wr(8'h22);
        check("fill.count_partial", 64'(count), 64'd0);
        wr(8'h33);
        check("fill.count", 64'(count), 64'd1);
        check("fill.empty", 64'(empty), 64'd0);
        pop();
        check("pop1.rvalid", 64'(rvalid), 64'd1);
        check("pop1.rdata",  64'(rdata),  64'h332211);
        check("pop1.rlanes", 64'(rlanes), 64'd3);
        check("pop1.count",  64'(count),  64'd0);
        check("pop1.empty",  64'(empty),  64'd1);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("pop1.rvalid_pulse", 64'(rvalid), 64'd0);
        check("pop1.rdata_hold",   64'(rdata),  64'h332211);

        // Partial chunk committed by w_next_chunk; lone w_next_chunk is a no-op.
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("nop_next.count", 64'(count), 64'd0);
        wr(8'hAA);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("partial.count", 64'(count), 64'd1);
        pop();
        check("partial.rlanes", 64'(rlanes), 64'd1);
`ifdef ASYM_CHUNK_FIFO_ZERO_PAD_EN
        check("partial.rdata", 64'(rdata), 64'h0000AA);
`else
        check("partial.lane0", 64'(rdata[7:0]), 64'hAA);
`endif

        // Fill both slots, overflow, then drain.
        wr(8'h01); wr(8'h02); wr(8'h03);
        wr(8'h04); wr(8'h05); wr(8'h06);
        check("full.w_full", 64'(w_full), 64'd1);
        check("full.count",  64'(count),  64'd2);
        check("full.ovf_before", 64'(ovf), 64'd0);
        wr(8'h55);
        check("ovf.ovf",   64'(ovf),   64'd1);
        check("ovf.count", 64'(count), 64'd2);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("full_next.count", 64'(count), 64'd2);
        pop();
        check("drain1.rdata",  64'(rdata),  64'h030201);
        check("drain1.rlanes", 64'(rlanes), 64'd3);
        check("drain1.w_full", 64'(w_full), 64'd0);
        check("drain1.count",  64'(count),  64'd1);
        pop();
        check("drain2.rdata", 64'(rdata), 64'h060504);
        check("drain2.count", 64'(count), 64'd0);

        // Pop in the commit cycle from empty underflows; next cycle succeeds.
        check("udf.before", 64'(udf), 64'd0);
        wr(8'h77); wr(8'h88);
        cyc(1'b0, 1'b1, 8'h99, 1'b0, 1'b1);
        check("udf.udf",    64'(udf),    64'd1);
        check("udf.rvalid", 64'(rvalid), 64'd0);
        check("udf.rdata_hold", 64'(rdata), 64'h060504);
        check("udf.count",  64'(count),  64'd1);
        pop();
        check("udf_next.rvalid", 64'(rvalid), 64'd1);
        check("udf_next.rdata",  64'(rdata),  64'h998877);

        // Commit/pop pairs walk both pointers around the two slots.
        for (int k = 1; k <= 5; k++) begin
            wr(8'(k)); wr(8'(8'h10 + k)); wr(8'(8'h20 + k));
            pop();
            exp_data = {8'(8'h20 + k), 8'(8'h10 + k), 8'(k)};
            check($sformatf("wrap%0d.rdata", k), 64'(rdata), 64'(exp_data));
            check($sformatf("wrap%0d.count", k), 64'(count), 64'd0);
        end

        // we together with w_next_chunk on lane 1 commits two lanes.
        wr(8'hC1);
        cyc(1'b0, 1'b1, 8'hC2, 1'b1, 1'b0);
        check("we_next.count", 64'(count), 64'd1);
        pop();
        check("we_next.rlanes", 64'(rlanes), 64'd2);
        check("we_next.lanes01", 64'(rdata[15:0]), 64'hC2C1);

        // Reset mid-operation with one committed chunk and two open lanes.
        wr(8'hD1); wr(8'hD2); wr(8'hD3);
        wr(8'hD4); wr(8'hD5);
        check("pre_rst.count", 64'(count), 64'd1);
        cyc(1'b1, 1'b1, 8'hD6, 1'b1, 1'b1);
        check_reset_state("mid_rst");
        wr(8'hE1);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("post_rst.count", 64'(count), 64'd1);
        pop();
        check("post_rst.rlanes", 64'(rlanes), 64'd1);
        check("post_rst.lane0",  64'(rdata[7:0]), 64'hE1);
        check("post_rst.empty",  64'(empty), 64'd1);
        pop();
        check("post_rst.udf",    64'(udf),    64'd1);
        check("post_rst.rvalid", 64'(rvalid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
